plic_lite: RTL and testbench
============================

Name: plic_lite

Overview:
Platform-level external interrupt arbiter for the HarvOS core.
- Collects NSRC peripheral interrupt lines and gates each through a pending/in-flight gateway.
- Selects the highest-priority enabled source above a threshold and drives the single external interrupt request into the core's interrupt controller (ext_irq_i).
- Software uses a memory-mapped claim/complete handshake to identify and retire the interrupt.

Parameters:
- NSRC, 8: number of interrupt sources, 1..31. Source IDs are 1..NSRC; ID 0 means "none".
- PRIO_W, 3: priority field width. Priority 0 means never interrupt.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- src_irq_i  in  NSRC  level interrupt lines, asynchronous to clk; bit i is source ID i+1
- reg_req_i  in  1  register access strobe, one bus op per cycle
- reg_we_i  in  1  1 = write, 0 = read
- reg_addr_i  in  8  byte address, word aligned
- reg_wdata_i  in  32  write data
- reg_rdata_o  out  32  read data, valid with reg_ack_o
- reg_ack_o  out  1  access completed
- ext_irq_o  out  1  to the core interrupt controller external input

Behaviour:
- Reset values: all registered outputs 0 (reg_rdata_o, reg_ack_o, ext_irq_o). Also 0: pending, in_flight, enable, threshold, all priorities, synchronisers, best_id, best_prio.
- Synchroniser: 2-flop synchroniser per source produces sync[i].
- Gateway, per source; the states are {pending, in_flight}:
  - IDLE → PEND when sync=1 and trigger fires.
  - PEND → INFL when claimed.
  - INFL → IDLE on complete with matching ID.
  - Pending holds even if the line drops while in PEND.
  - The line is ignored while PEND or INFL.
- Arbiter, combinational:
  - Candidate = pending & enable & (prio > threshold).
  - Winner = maximum prio; ties go to the lowest ID.
  - best_id and best_prio are registered each cycle; best_id = 0 if there is no candidate.
  - ext_irq_o is registered as (best_id != 0), in the same cycle as best_id.
- Latency: line sampled high at edge E1 → sync2 at E2 → pending at E3 → best_id and ext_irq_o at E4.
- Register map; unlisted addresses read 0 and ignore writes:
  - 0x00 PENDING, RO: bit i is pending of ID i.
  - 0x04 ENABLE, RW: bits [NSRC:1]; bit 0 reads 0.
  - 0x08 THRESHOLD, RW: [PRIO_W-1:0].
  - 0x0C CLAIM/COMPLETE:
    - Read returns the registered best_id. If it is non-zero, that source's pending is cleared and in_flight is set at the same edge.
    - Write of ID k sets in_flight[k]=0 only if in_flight[k]=1 and 1≤k≤NSRC. Otherwise the write is ignored.
  - 0x40+4*(k-1) PRIORITY[k], RW: [PRIO_W-1:0].
- Bus timing: reg_ack_o pulses exactly one cycle after reg_req_i. reg_rdata_o is registered, valid in the ack cycle, and 0 otherwise. Write side-effects land at the request edge.
- Simultaneous events:
  - Claim and the same source's line rising in one cycle: the line is ignored (source is now INFL).
  - Complete while the line is still high: pending re-sets at the next edge, and ext_irq_o re-asserts 2 cycles later.
  - Claim at the same edge that best_id changes: the claim returns the old registered value. It is always consistent, because pending is cleared only by claim.
  - A priority or enable change takes effect on ext_irq_o after 1 cycle.
- Reset mid-operation: all gateway state and ack are cleared immediately (asynchronously). An in-progress access is dropped with no ack.

Optional Feature:
- Macro: HARVOS_PLIC_EDGE_EN.
- Defined:
  - Adds a TRIGGER register at 0x10, RW, bits [NSRC:1], reset 0.
  - Bit = 1 makes the source rising-edge triggered: the gateway fires on a sync 0→1 transition, not on the level.
  - An edge arriving while PEND or INFL is dropped. A line held high after complete does not re-pend.
- Undefined:
  - All sources are level-triggered.
  - 0x10 reads 0 and ignores writes.
  - No edge-detect flops are instantiated.

Decomposition:
- plic_lite_pkg holds:
  - Localparams for the register offsets (PENDING, ENABLE, THRESHOLD, CLAIM, TRIGGER, PRIO_BASE).
  - ID_NONE = 0.
  - A max-NSRC constant of 31.
- Sub-module plic_gateway, instantiated NSRC times via generate. It holds the synchroniser, optional edge detect, and the pending/in_flight state. Inputs: claim and complete strobes. Outputs: pending and in_flight.
- Arbiter and register file live in plic_lite.

Test Plan:
1. Set PRIORITY[3]=5, enable bit3, threshold 0; raise src_irq_i[2] → ext_irq_o=1 at the 4th edge. CLAIM read returns 3 and PENDING=0. ext_irq_o=0 one cycle later.
2. Set IDs 2 and 5 to priority 4, ID 7 to priority 6, all pending → claims return 7, then 2, then 5 (completing each ID between claims).
3. Set threshold 4 with ID 2 at prio 4 pending → ext_irq_o stays 0. Change threshold to 3 → ext_irq_o=1 one cycle later.
4. Claim ID 3 with the line held high; write COMPLETE=3 → pending[3] reasserts next edge. Writing COMPLETE=9 or COMPLETE=4 (not in flight) has no effect.
5. CLAIM read with no candidate → returns 0 and no state change. Read of 0x20 → 0. reg_ack_o is exactly one cycle after every req.
6. With HARVOS_PLIC_EDGE_EN: set TRIGGER bit1 and hold line 1 high through claim and complete → no second pend. A new 0→1 pulse of 1 cycle width → pending[1]=1.

Source files
------------

// File: rtl/plic_lite_pkg.sv
// plic_lite shared definitions: register offsets, ID constants, gateway states.
// Optional edge-trigger support is selected with HARVOS_PLIC_EDGE_EN.
package plic_lite_pkg;

    localparam int MAX_NSRC = 31;
    localparam int ID_W     = 5;

    localparam logic [7:0] OFF_PENDING   = 8'h00;
    localparam logic [7:0] OFF_ENABLE    = 8'h04;
    localparam logic [7:0] OFF_THRESHOLD = 8'h08;
    localparam logic [7:0] OFF_CLAIM     = 8'h0C;
    localparam logic [7:0] OFF_TRIGGER   = 8'h10;
    localparam logic [7:0] OFF_PRIO_BASE = 8'h40;

    localparam logic [ID_W-1:0] ID_NONE = '0;

    // Encoding is {pending, in_flight}
    typedef enum logic [1:0] {
        GW_IDLE = 2'b00,
        GW_PEND = 2'b10,
        GW_INFL = 2'b01
    } gw_state_e;

endpackage

// File: rtl/plic_lite_gateway.sv
// plic_gateway: per-source synchroniser, optional edge detect (HARVOS_PLIC_EDGE_EN)
// and pending/in_flight state. Ports: clk, rst, line, [edge_mode], claim, complete -> pending, in_flight.
module plic_gateway
    import plic_lite_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line,
`ifdef HARVOS_PLIC_EDGE_EN
    input  logic edge_mode,
`endif
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_flight
);

    logic      sync1;
    logic      sync2;
    logic      fire;
    gw_state_e state;
    gw_state_e state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
        end
    end

`ifdef HARVOS_PLIC_EDGE_EN
    logic sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync3 <= 1'b0;
        end else begin
            sync3 <= sync2;
        end
    end

    assign fire = edge_mode ? (sync2 & ~sync3) : sync2;
`else
    assign fire = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The line is only looked at in IDLE, so anything arriving
    // while pending or in flight is dropped.
    always_comb begin
        state_nxt = state;
        unique case (state)
            GW_IDLE: if (fire)     state_nxt = GW_PEND;
            GW_PEND: if (claim)    state_nxt = GW_INFL;
            GW_INFL: if (complete) state_nxt = GW_IDLE;
            default:               state_nxt = GW_IDLE;
        endcase
    end

    always_comb begin
        pending   = (state == GW_PEND);
        in_flight = (state == GW_INFL);
    end

endmodule

// File: rtl/plic_lite.sv
// plic_lite: external interrupt arbiter with claim/complete register interface.
// Ports: clk, rst, src_irq_i, reg_* bus (req/we/addr/wdata -> rdata/ack), ext_irq_o. Macro: HARVOS_PLIC_EDGE_EN.
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_irq_i,
    input  logic            reg_req_i,
    input  logic            reg_we_i,
    input  logic [7:0]      reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic [31:0]     reg_rdata_o,
    output logic            reg_ack_o,
    output logic            ext_irq_o
);

    logic [NSRC-1:0]   pend;
    logic [NSRC-1:0]   infl;
    logic [NSRC-1:0]   en;
    logic [NSRC-1:0]   claim;
    logic [NSRC-1:0]   complete;
    logic [PRIO_W-1:0] thresh;
    logic [PRIO_W-1:0] prio [NSRC];

    logic [ID_W-1:0]   best_id;
    logic [ID_W-1:0]   nxt_id;
    logic [PRIO_W-1:0] best_prio;
    logic [PRIO_W-1:0] nxt_prio;

    logic              rd_en;
    logic              wr_en;
    logic              prio_sel;
    logic [5:0]        pidx;
    logic [31:0]       rd_val;

`ifdef HARVOS_PLIC_EDGE_EN
    logic [NSRC-1:0]   trig;
`endif

    assign rd_en    = reg_req_i & ~reg_we_i;
    assign wr_en    = reg_req_i &  reg_we_i;
    assign prio_sel = (reg_addr_i >= OFF_PRIO_BASE) && (reg_addr_i[1:0] == 2'b00);
    assign pidx     = reg_addr_i[7:2] - OFF_PRIO_BASE[7:2];

    for (genvar g = 0; g < NSRC; g++) begin : g_gw
        plic_gateway u_gw (
            .clk       (clk),
            .rst       (rst),
            .line      (src_irq_i[g]),
`ifdef HARVOS_PLIC_EDGE_EN
            .edge_mode (trig[g]),
`endif
            .claim     (claim[g]),
            .complete  (complete[g]),
            .pending   (pend[g]),
            .in_flight (infl[g])
        );
    end

    // Starting the search at the threshold with a strict compare filters
    // out sub-threshold sources and keeps the lowest ID on ties.
    always_comb begin
        nxt_id   = ID_NONE;
        nxt_prio = thresh;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && en[i] && (prio[i] > nxt_prio)) begin
                nxt_id   = ID_W'(i + 1);
                nxt_prio = prio[i];
            end
        end
        if (nxt_id == ID_NONE) begin
            nxt_prio = '0;
        end
    end

    // Claim retires the registered winner, so it always matches
    // the value returned by the same read.
    always_comb begin
        claim    = '0;
        complete = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim[i] = rd_en && (reg_addr_i == OFF_CLAIM) &&
                       (best_prio != '0) && (best_id == ID_W'(i + 1));
            complete[i] = wr_en && (reg_addr_i == OFF_CLAIM) &&
                          (reg_wdata_i == 32'(i + 1)) && infl[i];
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_addr_i)
            OFF_PENDING:   rd_val = 32'({pend, 1'b0});
            OFF_ENABLE:    rd_val = 32'({en, 1'b0});
            OFF_THRESHOLD: rd_val = 32'(thresh);
            OFF_CLAIM:     rd_val = 32'(best_id);
`ifdef HARVOS_PLIC_EDGE_EN
            OFF_TRIGGER:   rd_val = 32'({trig, 1'b0});
`endif
            default: begin
                for (int i = 0; i < NSRC; i++) begin
                    if (prio_sel && (pidx == 6'(i))) begin
                        rd_val = 32'(prio[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_ack_o   <= 1'b0;
            reg_rdata_o <= '0;
            ext_irq_o   <= 1'b0;
            best_id     <= ID_NONE;
            best_prio   <= '0;
            en          <= '0;
            thresh      <= '0;
`ifdef HARVOS_PLIC_EDGE_EN
            trig        <= '0;
`endif
            for (int i = 0; i < NSRC; i++) begin
                prio[i] <= '0;
            end
        end else begin
            reg_ack_o   <= reg_req_i;
            reg_rdata_o <= rd_en ? rd_val : '0;
            best_id     <= nxt_id;
            best_prio   <= nxt_prio;
            ext_irq_o   <= (nxt_id != ID_NONE);
            if (wr_en) begin
                case (reg_addr_i)
                    OFF_ENABLE:    en     <= reg_wdata_i[NSRC:1];
                    OFF_THRESHOLD: thresh <= reg_wdata_i[PRIO_W-1:0];
`ifdef HARVOS_PLIC_EDGE_EN
                    OFF_TRIGGER:   trig   <= reg_wdata_i[NSRC:1];
`endif
                    default: begin
                        for (int i = 0; i < NSRC; i++) begin
                            if (prio_sel && (pidx == 6'(i))) begin
                                prio[i] <= reg_wdata_i[PRIO_W-1:0];
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: bus reads scored through an expected-value
// queue, interrupt output checked directly at fixed cycle offsets.
module tb_plic_lite;

    localparam int NSRC   = 8;
    localparam int PRIO_W = 3;

    localparam logic [7:0] A_PEND  = 8'h00;
    localparam logic [7:0] A_EN    = 8'h04;
    localparam logic [7:0] A_THR   = 8'h08;
    localparam logic [7:0] A_CLAIM = 8'h0C;
    localparam logic [7:0] A_TRIG  = 8'h10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] src = '0;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [7:0]      addr = '0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            ack;
    logic            irq;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        req_q = 1'b0;

    plic_lite #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_irq_i   (src),
        .reg_req_i   (req),
        .reg_we_i    (we),
        .reg_addr_i  (addr),
        .reg_wdata_i (wdata),
        .reg_rdata_o (rdata),
        .reg_ack_o   (ack),
        .ext_irq_o   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) req_q <= req;

    // Monitor: every ack pops one expected read value
    always @(negedge clk) begin
        logic [31:0] e;
        string       nm;
        if (!rst) begin
            if (req_q || ack) begin
                n_cmp++;
                if (ack !== req_q) begin
                    n_bad++;
                    $display("FAIL ack_timing: ack=%b required %b at %0t", ack, req_q, $time);
                end
            end
            if (ack === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ack: rdata=%h with empty queue at %0t", rdata, $time);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (rdata !== e) begin
                        n_bad++;
                        $display("FAIL %s: rdata=%h required %h at %0t", nm, rdata, e, $time);
                    end
                end
            end else begin
                n_cmp++;
                if (rdata !== 32'h0) begin
                    n_bad++;
                    $display("FAIL rdata_idle: rdata=%h required 0 at %0t", rdata, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        exp_q.push_back(32'h0);
        name_q.push_back($sformatf("wr_%h", a));
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0; addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        rd("reset_pending", A_PEND, 32'h0);
        rd("reset_enable", A_EN, 32'h0);
        rd("reset_prio3", 8'h48, 32'h0);

        // 1: single source latency and claim
        wr(8'h48, 32'd5);
        wr(A_EN, 32'h08);
        wr(A_THR, 32'd0);
        src[2] = 1'b1;
        tick(3);
        chk("t1_irq_e3", 32'(irq), 32'h0);
        tick(1);
        chk("t1_irq_e4", 32'(irq), 32'h1);
        rd("t1_claim", A_CLAIM, 32'd3);
        chk("t1_irq_claim_edge", 32'(irq), 32'h1);
        tick(1);
        chk("t1_irq_after", 32'(irq), 32'h0);
        rd("t1_pending", A_PEND, 32'h0);
        src[2] = 1'b0;
        tick(3);
        wr(A_CLAIM, 32'd3);

        // 2: priority order and tie-break
        wr(8'h44, 32'd4);
        wr(8'h50, 32'd4);
        wr(8'h58, 32'd6);
        wr(A_EN, 32'hAC);
        src = 8'h52;
        tick(4);
        chk("t2_irq", 32'(irq), 32'h1);
        src = '0;
        rd("t2_pending", A_PEND, 32'hA4);
        rd("t2_claim7", A_CLAIM, 32'd7);
        wr(A_CLAIM, 32'd7);
        rd("t2_claim2", A_CLAIM, 32'd2);
        wr(A_CLAIM, 32'd2);
        rd("t2_claim5", A_CLAIM, 32'd5);
        wr(A_CLAIM, 32'd5);
        rd("t2_claim_none", A_CLAIM, 32'd0);
        chk("t2_irq_idle", 32'(irq), 32'h0);

        // 3: threshold boundary
        wr(A_THR, 32'd4);
        src[1] = 1'b1;
        tick(5);
        chk("t3_irq_at_thr", 32'(irq), 32'h0);
        rd("t3_claim_at_thr", A_CLAIM, 32'd0);
        wr(A_THR, 32'd3);
        chk("t3_irq_thr_edge", 32'(irq), 32'h0);
        tick(1);
        chk("t3_irq_below_thr", 32'(irq), 32'h1);
        src[1] = 1'b0;
        rd("t3_claim2", A_CLAIM, 32'd2);
        wr(A_CLAIM, 32'd2);
        wr(A_THR, 32'd0);

        // 4: complete with line held, bogus completes
        src[2] = 1'b1;
        tick(4);
        chk("t4_irq", 32'(irq), 32'h1);
        rd("t4_claim3", A_CLAIM, 32'd3);
        tick(1);
        rd("t4_pend_infl", A_PEND, 32'h0);
        wr(A_CLAIM, 32'd9);
        wr(A_CLAIM, 32'd4);
        tick(2);
        rd("t4_pend_bogus", A_PEND, 32'h0);
        chk("t4_irq_bogus", 32'(irq), 32'h0);
        wr(A_CLAIM, 32'd3);
        chk("t4_irq_c0", 32'(irq), 32'h0);
        tick(1);
        chk("t4_irq_c1", 32'(irq), 32'h0);
        rd("t4_pend_repend", A_PEND, 32'h08);
        chk("t4_irq_c2", 32'(irq), 32'h1);
        src[2] = 1'b0;
        rd("t4_claim3b", A_CLAIM, 32'd3);
        tick(2);
        wr(A_CLAIM, 32'd3);

        // 5: idle claim, unmapped and register readback
        rd("t5_claim_none", A_CLAIM, 32'd0);
        rd("t5_pending", A_PEND, 32'h0);
        rd("t5_unmapped", 8'h20, 32'h0);
        rd("t5_enable", A_EN, 32'hAC);
        rd("t5_prio3", 8'h48, 32'd5);
        rd("t5_thr", A_THR, 32'd0);
        wr(A_EN, 32'hFFFF_FFFF);
        rd("t5_enable_mask", A_EN, 32'h1FE);
        wr(A_EN, 32'hAC);
        wr(8'h60, 32'd7);
        rd("t5_prio_oob", 8'h60, 32'h0);
        wr(A_THR, 32'hFFFF_FFFF);
        rd("t5_thr_mask", A_THR, 32'd7);
        wr(A_THR, 32'd0);
`ifndef HARVOS_PLIC_EDGE_EN
        wr(A_TRIG, 32'hFFFF_FFFF);
        rd("t5_trig_absent", A_TRIG, 32'h0);
`else
        // 6: edge-triggered source
        wr(A_TRIG, 32'h02);
        rd("t6_trig", A_TRIG, 32'h02);
        wr(8'h40, 32'd3);
        wr(A_EN, 32'hAE);
        src[0] = 1'b1;
        tick(4);
        chk("t6_irq", 32'(irq), 32'h1);
        rd("t6_claim1", A_CLAIM, 32'd1);
        tick(2);
        wr(A_CLAIM, 32'd1);
        tick(3);
        rd("t6_no_repend", A_PEND, 32'h0);
        chk("t6_irq_held", 32'(irq), 32'h0);
        src[0] = 1'b0;
        tick(3);
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(3);
        rd("t6_pulse_pend", A_PEND, 32'h02);
        rd("t6_claim1b", A_CLAIM, 32'd1);
        tick(1);
        wr(A_CLAIM, 32'd1);
        wr(A_TRIG, 32'h0);
`endif

        // Asynchronous reset mid-operation
        src[4] = 1'b1;
        tick(4);
        chk("rst_irq_before", 32'(irq), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_irq_async", 32'(irq), 32'h0);
        chk("rst_ack_async", 32'(ack), 32'h0);
        src = '0;
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        rd("rst_pending", A_PEND, 32'h0);
        rd("rst_enable", A_EN, 32'h0);
        rd("rst_claim", A_CLAIM, 32'h0);

        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
